// File: rtl/hood_pkg.sv
// rtl/hood_pkg.sv - mode codes and led helper for the range-hood mode controller
package hood_pkg;

    localparam int MODE_STANDBY = 0;
    localparam int LED_MAX_W    = 32;

    // Self-clean sits directly above the boost speed
    function automatic int MODE_CLEAN(input int n);
        return n + 1;
    endfunction

    function automatic logic [LED_MAX_W-1:0] led_onehot(input int m);
        return LED_MAX_W'(1) << m;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - CLK_HZ divider producing a one-cycle tick, with synchronous restart
module sec_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = !i_restart && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hood_mode_ctrl.sv
// rtl/hood_mode_ctrl.sv - range-hood fan mode FSM with boost and timed self-clean countdown
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int NUM_SPEEDS = 3,
    parameter int CLK_HZ     = 100_000_000,
    parameter int BOOST_SEC  = 60,
    parameter int CLEAN_SEC  = 180,
    parameter int SEC_W      = 8,
    localparam int MODE_W    = $clog2(NUM_SPEEDS + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_on,
    input  logic                  menu_btn,
    input  logic [NUM_SPEEDS-1:0] speed_btn,
    input  logic                  clean_btn,
    input  logic                  boost_en,
    output logic [MODE_W-1:0]     mode,
    output logic [NUM_SPEEDS+1:0] led,
    output logic [SEC_W-1:0]      remaining_sec,
    output logic                  menu_armed
);

    localparam int LW = NUM_SPEEDS + 2;
    localparam logic [MODE_W-1:0] M_STANDBY = MODE_W'(MODE_STANDBY);
    localparam logic [MODE_W-1:0] M_BOOST   = MODE_W'(NUM_SPEEDS);
    localparam logic [MODE_W-1:0] M_TOP_SPD = MODE_W'(NUM_SPEEDS - 1);
    localparam logic [MODE_W-1:0] M_CLEAN   = MODE_W'(MODE_CLEAN(NUM_SPEEDS));

    logic [MODE_W-1:0]     r_mode;
    logic [LW-1:0]         r_led;
    logic [SEC_W-1:0]      r_rem;
    logic                  r_armed;
    logic                  r_ret;
    logic                  r_menu_prev;
    logic                  r_clean_prev;
    logic [NUM_SPEEDS-1:0] r_speed_prev;

    logic                  w_menu_e;
    logic                  w_clean_e;
    logic [NUM_SPEEDS-1:0] w_speed_e;
    logic                  w_spd_any;
    logic [MODE_W-1:0]     w_spd_idx;
    logic                  w_spd_ok;
    logic                  w_timed;
    logic                  w_restart;
    logic                  w_tick;
    logic                  w_rem_last;

    logic [MODE_W-1:0]     w_mode_nxt;
    logic [SEC_W-1:0]      w_rem_nxt;
    logic                  w_armed_nxt;
    logic                  w_ret_nxt;

    assign w_menu_e   = menu_btn & ~r_menu_prev;
    assign w_clean_e  = clean_btn & ~r_clean_prev;
    assign w_speed_e  = speed_btn & ~r_speed_prev;
    assign w_spd_any  = |w_speed_e;
    assign w_spd_ok   = (w_spd_idx != M_BOOST) || boost_en;
    assign w_timed    = (r_mode == M_BOOST) || (r_mode == M_CLEAN);
    assign w_rem_last = (r_rem == SEC_W'(1));

    // Divider is held at zero outside timed modes, so it starts fresh on every entry
    assign w_restart = !power_on || !w_timed;

    sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_spd_idx = '0;
        for (int k = NUM_SPEEDS - 1; k >= 0; k--) begin
            if (w_speed_e[k]) begin
                w_spd_idx = MODE_W'(k + 1);
            end
        end
    end

    always_comb begin
        w_mode_nxt  = r_mode;
        w_rem_nxt   = r_rem;
        w_armed_nxt = r_armed;
        w_ret_nxt   = r_ret;
        if (!power_on) begin
            w_mode_nxt  = M_STANDBY;
            w_rem_nxt   = '0;
            w_armed_nxt = 1'b0;
            w_ret_nxt   = 1'b0;
        end else if (r_mode == M_STANDBY) begin
            if (w_menu_e) begin
                w_armed_nxt = !r_armed;
            end else if (r_armed && w_spd_any) begin
                // A refused boost request still consumes the selection slot
                if (w_spd_ok) begin
                    w_mode_nxt  = w_spd_idx;
                    w_armed_nxt = 1'b0;
                    if (w_spd_idx == M_BOOST) begin
                        w_rem_nxt = SEC_W'(BOOST_SEC);
                        w_ret_nxt = 1'b0;
                    end
                end
            end else if (r_armed && w_clean_e) begin
                w_mode_nxt  = M_CLEAN;
                w_armed_nxt = 1'b0;
                w_rem_nxt   = SEC_W'(CLEAN_SEC);
            end
        end else if (r_mode == M_BOOST) begin
            if (!boost_en) begin
                w_mode_nxt = M_STANDBY;
                w_rem_nxt  = '0;
                w_ret_nxt  = 1'b0;
            end else begin
                if (w_menu_e) begin
                    w_ret_nxt = 1'b1;
                end
                if (w_tick) begin
                    if (w_rem_last) begin
                        w_mode_nxt = (r_ret || w_menu_e) ? M_TOP_SPD : M_STANDBY;
                        w_rem_nxt  = '0;
                        w_ret_nxt  = 1'b0;
                    end else begin
                        w_rem_nxt = r_rem - 1'b1;
                    end
                end
            end
        end else if (r_mode == M_CLEAN) begin
            if (w_tick) begin
                if (w_rem_last) begin
                    w_mode_nxt = M_STANDBY;
                    w_rem_nxt  = '0;
                end else begin
                    w_rem_nxt = r_rem - 1'b1;
                end
            end
        end else begin
            if (w_menu_e) begin
                w_mode_nxt = M_STANDBY;
            end else if (w_spd_any && (w_spd_idx != r_mode) && w_spd_ok) begin
                w_mode_nxt = w_spd_idx;
                if (w_spd_idx == M_BOOST) begin
                    w_rem_nxt = SEC_W'(BOOST_SEC);
                    w_ret_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode       <= M_STANDBY;
            r_led        <= '0;
            r_rem        <= '0;
            r_armed      <= 1'b0;
            r_ret        <= 1'b0;
            r_menu_prev  <= 1'b0;
            r_clean_prev <= 1'b0;
            r_speed_prev <= '0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_led        <= power_on ? LW'(led_onehot(int'(w_mode_nxt))) : '0;
            r_rem        <= w_rem_nxt;
            r_armed      <= w_armed_nxt;
            r_ret        <= w_ret_nxt;
            r_menu_prev  <= menu_btn;
            r_clean_prev <= clean_btn;
            r_speed_prev <= speed_btn;
        end
    end

    assign mode          = r_mode;
    assign led           = r_led;
    assign remaining_sec = r_rem;
    assign menu_armed    = r_armed;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb/tb_hood_mode_ctrl.sv - self-checking bench for hood_mode_ctrl
module tb_hood_mode_ctrl;

    localparam int N  = 3;
    localparam int HZ = 10;
    localparam int BS = 4;
    localparam int CS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       power_on = 1'b0;
    logic       menu_btn = 1'b0;
    logic [2:0] speed_btn = 3'b000;
    logic       clean_btn = 1'b0;
    logic       boost_en = 1'b0;
    logic [2:0] mode;
    logic [4:0] led;
    logic [7:0] remaining_sec;
    logic       menu_armed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hood_mode_ctrl #(
        .NUM_SPEEDS (N),
        .CLK_HZ     (HZ),
        .BOOST_SEC  (BS),
        .CLEAN_SEC  (CS),
        .SEC_W      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_on      (power_on),
        .menu_btn      (menu_btn),
        .speed_btn     (speed_btn),
        .clean_btn     (clean_btn),
        .boost_en      (boost_en),
        .mode          (mode),
        .led           (led),
        .remaining_sec (remaining_sec),
        .menu_armed    (menu_armed)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: timed modes tracked as elapsed cycles since entry; seconds left derived arithmetically
    int         m_mode, m_el, m_dur;
    bit         m_armed, m_ret, m_pwr;
    bit         p_menu, p_clean;
    logic [2:0] p_spd;

    always @(posedge clk or negedge rst) begin
        bit         me, ce;
        logic [2:0] se;
        int         j;
        if (!rst) begin
            m_mode = 0; m_el = 0; m_dur = 0;
            m_armed = 0; m_ret = 0; m_pwr = 0;
            p_menu = 0; p_clean = 0; p_spd = 3'b000;
        end else begin
            me = menu_btn && !p_menu;
            ce = clean_btn && !p_clean;
            se = speed_btn & ~p_spd;
            p_menu = menu_btn; p_clean = clean_btn; p_spd = speed_btn;
            j = 0;
            for (int k = 2; k >= 0; k--) if (se[k]) j = k + 1;
            m_pwr = power_on;
            if (!power_on) begin
                m_mode = 0; m_armed = 0; m_ret = 0; m_dur = 0; m_el = 0;
            end else if (m_mode == 0) begin
                if (me) m_armed = !m_armed;
                else if (m_armed && j != 0) begin
                    if (j < N || boost_en) begin
                        m_mode = j; m_armed = 0;
                        if (j == N) begin m_dur = BS; m_el = 0; m_ret = 0; end
                    end
                end else if (m_armed && ce) begin
                    m_mode = N + 1; m_armed = 0; m_dur = CS; m_el = 0;
                end
            end else if (m_mode == N) begin
                if (!boost_en) begin
                    m_mode = 0; m_ret = 0; m_dur = 0;
                end else begin
                    if (me) m_ret = 1;
                    m_el++;
                    if (m_el == m_dur * HZ) begin
                        m_mode = m_ret ? N - 1 : 0; m_ret = 0; m_dur = 0;
                    end
                end
            end else if (m_mode == N + 1) begin
                m_el++;
                if (m_el == m_dur * HZ) begin m_mode = 0; m_dur = 0; end
            end else begin
                if (me) m_mode = 0;
                else if (j != 0 && j != m_mode && (j < N || boost_en)) begin
                    m_mode = j;
                    if (j == N) begin m_dur = BS; m_el = 0; m_ret = 0; end
                end
            end
        end
    end

    function automatic int exp_rem();
        if (m_mode == N || m_mode == N + 1) return m_dur - m_el / HZ;
        return 0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("model_mode", int'(mode), m_mode);
            chk("model_led", int'(led), m_pwr ? (1 << m_mode) : 0);
            chk("model_rem", int'(remaining_sec), exp_rem());
            chk("model_armed", int'(menu_armed), int'(m_armed));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic [2:0] s, input logic c);
        menu_btn = m; speed_btn = s; clean_btn = c;
        @(negedge clk);
        menu_btn = 1'b0; speed_btn = 3'b000; clean_btn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        #2 rst = 1'b0;
        #1;
        chk("reset_mode", int'(mode), 0);
        chk("reset_led", int'(led), 0);
        chk("reset_rem", int'(remaining_sec), 0);
        chk("reset_armed", int'(menu_armed), 0);
        power_on = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk("pwr_led0", int'(led), 5'b00001);

        // Menu toggling and normal speeds
        press(1, 3'b000, 0);
        chk("armed_on", int'(menu_armed), 1);
        press(1, 3'b000, 0);
        chk("armed_off", int'(menu_armed), 0);
        press(1, 3'b000, 0);
        press(0, 3'b001, 0);
        chk("spd1_mode", int'(mode), 1);
        chk("spd1_led", int'(led), 5'b00010);
        chk("spd1_armed", int'(menu_armed), 0);
        press(0, 3'b010, 0);
        chk("spd2_mode", int'(mode), 2);
        press(1, 3'b000, 0);
        chk("stby_mode", int'(mode), 0);
        chk("stby_led", int'(led), 5'b00001);

        // Boost refused, then granted and timed
        press(1, 3'b000, 0);
        press(0, 3'b100, 0);
        chk("boost_deny_mode", int'(mode), 0);
        chk("boost_deny_armed", int'(menu_armed), 1);
        boost_en = 1'b1;
        press(0, 3'b100, 0);
        chk("boost_mode", int'(mode), 3);
        chk("boost_rem", int'(remaining_sec), 4);
        cnt = 1;
        while (mode != 3'd0 && cnt < 100) begin
            step(1);
            cnt++;
            if (cnt == 9) chk("boost_rem_c9", int'(remaining_sec), 4);
            if (cnt == 10) chk("boost_rem_c10", int'(remaining_sec), 3);
        end
        chk("boost_len", cnt, 40);

        // Boost with return flag
        press(1, 3'b000, 0);
        press(0, 3'b100, 0);
        step(13);
        press(1, 3'b000, 0);
        step(23);
        chk("ret_c39_mode", int'(mode), 3);
        chk("ret_c39_rem", int'(remaining_sec), 1);
        step(1);
        chk("ret_c40_mode", int'(mode), 2);
        chk("ret_c40_rem", int'(remaining_sec), 0);
        chk("ret_c40_led", int'(led), 5'b00100);
        press(1, 3'b000, 0);

        // boost_en drop mid-boost
        press(1, 3'b000, 0);
        press(0, 3'b100, 0);
        step(10);
        boost_en = 1'b0;
        step(1);
        chk("drop_mode", int'(mode), 0);
        chk("drop_rem", int'(remaining_sec), 0);
        boost_en = 1'b1;

        // Self-clean ignores buttons
        press(1, 3'b000, 0);
        press(0, 3'b000, 1);
        chk("clean_mode", int'(mode), 4);
        chk("clean_led", int'(led), 5'b10000);
        chk("clean_rem", int'(remaining_sec), 6);
        press(0, 3'b001, 0);
        press(1, 3'b000, 0);
        chk("clean_ign_mode", int'(mode), 4);
        step(54);
        chk("clean_c59_mode", int'(mode), 4);
        chk("clean_c59_rem", int'(remaining_sec), 1);
        step(1);
        chk("clean_end_mode", int'(mode), 0);

        // Power drop during clean
        press(1, 3'b000, 0);
        press(0, 3'b000, 1);
        step(5);
        power_on = 1'b0;
        step(1);
        chk("pwroff_led", int'(led), 0);
        chk("pwroff_rem", int'(remaining_sec), 0);
        chk("pwroff_mode", int'(mode), 0);
        power_on = 1'b1;
        step(1);
        chk("pwron_led", int'(led), 5'b00001);

        // Asynchronous reset mid-boost
        press(1, 3'b000, 0);
        press(0, 3'b100, 0);
        step(5);
        chk("pre_rst_mode", int'(mode), 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_mode", int'(mode), 0);
        chk("arst_led", int'(led), 0);
        chk("arst_rem", int'(remaining_sec), 0);
        chk("arst_armed", int'(menu_armed), 0);
        @(negedge clk);
        rst = 1'b1;
        step(3);
        chk("post_rst_led", int'(led), 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
